// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters,
// with divider wait/timeout and a held response handshake.
module alu_arbiter #(
   parameter int DIV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic        alu_done,
   input  logic [31:0] alu_res_high,
   input  logic [31:0] alu_res_low,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic        rsp_err,
   output logic [31:0] rsp_high,
   output logic [31:0] rsp_low
);
   localparam int CW = $clog2(DIV_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, EXEC, WAIT_DIV, RESP} state_t;
   state_t state, state_n;
   logic pri, gnt, acc, illegal, div_end;
   logic [3:0] op_sel;
   logic [31:0] a_sel, b_sel;
   logic [CW-1:0] cnt;
   // pri names the requester favoured when both are valid
   always_comb begin
      gnt = req1_valid & (~req0_valid | pri);
      req0_ready = state == IDLE && req0_valid && !gnt;
      req1_ready = state == IDLE && gnt;
      acc = req0_ready | req1_ready;
      op_sel = gnt ? req1_op : req0_op;
      a_sel = gnt ? req1_a : req0_a;
      b_sel = gnt ? req1_b : req0_b;
      illegal = op_sel >= 4'd13;
      div_end = alu_done || cnt == CNT_LAST;
      state_n = state;
      case (state)
         IDLE:     if (acc) state_n = illegal ? RESP : (op_sel == 4'd3 ? WAIT_DIV : EXEC);
         EXEC:     state_n = RESP;
         WAIT_DIV: if (div_end) state_n = RESP;
         default:  if (rsp_ready) state_n = IDLE;
      endcase
   end
   assign rsp_valid = state == RESP;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pri <= 1'b0;
         cnt <= '0;
         alu_op <= '0;
         alu_a <= '0;
         alu_b <= '0;
         rsp_id <= 1'b0;
         rsp_err <= 1'b0;
         rsp_high <= '0;
         rsp_low <= '0;
      end else begin
         state <= state_n;
         if (acc) begin
            pri <= ~gnt;
            alu_op <= op_sel;
            alu_a <= a_sel;
            alu_b <= b_sel;
            rsp_id <= gnt;
            cnt <= '0;
            rsp_err <= illegal;
            rsp_high <= '0;
            rsp_low <= '0;
         end
         if (state == EXEC || (state == WAIT_DIV && alu_done)) begin
            rsp_err <= 1'b0;
            rsp_high <= alu_res_high;
            rsp_low <= alu_res_low;
         end else if (state == WAIT_DIV) begin
            // on expiry the results stay at the zeros loaded on accept
            cnt <= cnt + 1'b1;
            rsp_err <= div_end;
         end
      end
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 64, max cycles waited for divider done before error response.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester N command valid.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  command accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_op / req1_op  input  4 each  ALU opcode.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-008 SHALL have ports alu_a, alu_b  output  32 each  registered operands to shared ALU.
REQ-009 SHALL have port alu_op  output  4  registered opcode to shared ALU.
REQ-010 SHALL have port alu_done  input  1  divider completion from ALU.
REQ-011 SHALL have ports alu_res_high, alu_res_low  input  32 each  ALU result halves.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumer accepts.
REQ-014 SHALL have port rsp_id  output  1  requester index of response.
REQ-015 SHALL have port rsp_err  output  1  illegal opcode or divider timeout.
REQ-016 SHALL have ports rsp_high, rsp_low  output  32 each  captured result.

Function
REQ-017 SHALL implement FSM IDLE, EXEC, WAIT_DIV, RESP; reset state IDLE.
REQ-018 SHALL assert reqN_ready only in IDLE, only for granted N, combinationally from valids and rr pointer.
REQ-019 SHALL grant: only one valid -> that one; both valid -> requester not last granted (round-robin); rr pointer updates on accept only.
REQ-020 SHALL on accept in cycle T register op/a/b into alu_op/alu_a/alu_b (visible T+1) and latch id; alu_* hold stable until next accept.
REQ-021 SHALL on accept with op 0-2,4-12 go EXEC; op 3 (divide) go WAIT_DIV; op 13-15 go RESP directly with rsp_err=1, rsp_high=rsp_low=0, ALU inputs still updated.
REQ-022 SHALL in EXEC (T+1) capture alu_res_high/low into rsp_high/low and go RESP; rsp_valid high from T+2.
REQ-023 SHALL in WAIT_DIV count cycles from 0; first cycle alu_done=1 -> capture results, rsp_err=0, go RESP.
REQ-024 SHALL when counter reaches DIV_TIMEOUT-1 without alu_done -> rsp_err=1, results 0, go RESP; alu_done and expiry same cycle: alu_done wins.
REQ-025 SHALL hold rsp_valid, rsp_id, rsp_err, rsp_high, rsp_low constant in RESP until rsp_valid&rsp_ready; then go IDLE.
REQ-026 SHALL not accept a new request in the cycle a response is consumed; minimum spacing 3 cycles per op.
REQ-027 SHALL ignore alu_done outside WAIT_DIV.
REQ-028 SHALL not drop or reorder requests: non-granted valid waits; requesters must hold valid/op/a/b until ready.

Reset
REQ-029 SHALL on rst low asynchronously clear state to IDLE, rr pointer to favour req0, counter to 0, all outputs (alu_*, rsp_*) to 0; in-flight operation discarded, no response.
REQ-030 SHALL resume on first rising clk after rst deasserts.

Verification
REQ-031 Add: req0 op=0 a=5 b=7 accepted cycle T, alu_res_low=12 -> rsp_valid T+2, rsp_id=0, rsp_low=12, rsp_err=0.
REQ-032 Contention: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; none starved.
REQ-033 Divide: op=3 a=100 b=7, alu_done after 33 cycles with high=2 low=14 -> rsp_high=2, rsp_low=14, rsp_err=0, next cycle after done.
REQ-034 Timeout: op=3, alu_done held 0, DIV_TIMEOUT=64 -> rsp_valid with rsp_err=1, results 0, 65 cycles after accept.
REQ-035 Backpressure/illegal: op=14, rsp_ready=0 for 10 cycles -> rsp_err=1 held stable, req*_ready=0 until consumed.
REQ-036 Reset mid-divide: rst low during WAIT_DIV -> all outputs 0 immediately, no response after release, next request served normally.
